inst_encoder: RTL and testbench

//  Encodes compact micro-op requests (op enum + rd/rs/rt/imm) into 32-bit MIPS32 instruction words for the decode stage.

---
 rtl/inst_encoder_pkg.sv | 76 +++++++
 rtl/inst_encoder_word.sv | 81 ++++++++
 rtl/inst_encoder.sv | 157 +++++++++++++++
 tb/tb_inst_encoder.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/inst_encoder_pkg.sv
// Shared op enum, MIPS32 opcode/func constants and word-building helpers for the
// micro-op to instruction encoder.
package inst_encoder_pkg;

    typedef enum logic [5:0] {
        ENC_OR, ENC_AND, ENC_XOR, ENC_NOR,
        ENC_SLL, ENC_SRL, ENC_SRA, ENC_SLLV, ENC_SRLV, ENC_SRAV,
        ENC_MOVZ, ENC_MOVN, ENC_MFHI, ENC_MTHI, ENC_MFLO, ENC_MTLO,
        ENC_SLT, ENC_SLTU, ENC_ADD, ENC_ADDU, ENC_SUB, ENC_SUBU,
        ENC_MULT, ENC_MULTU,
        ENC_ORI, ENC_ANDI, ENC_XORI, ENC_LUI,
        ENC_ADDI, ENC_ADDIU, ENC_SLTI, ENC_SLTIU,
        ENC_CLZ, ENC_CLO, ENC_MUL,
        ENC_NOP, ENC_LI
    } enc_op_e;

    localparam logic [5:0] ENC_NUM_OPS = 6'd37;

    localparam logic [5:0] EXE_SPECIAL  = 6'b000000;
    localparam logic [5:0] EXE_SPECIAL2 = 6'b011100;
    localparam logic [5:0] EXE_ADDI     = 6'h08;
    localparam logic [5:0] EXE_ADDIU    = 6'h09;
    localparam logic [5:0] EXE_SLTI     = 6'h0A;
    localparam logic [5:0] EXE_SLTIU    = 6'h0B;
    localparam logic [5:0] EXE_ANDI     = 6'h0C;
    localparam logic [5:0] EXE_ORI      = 6'h0D;
    localparam logic [5:0] EXE_XORI     = 6'h0E;
    localparam logic [5:0] EXE_LUI      = 6'h0F;

    localparam logic [5:0] EXE_SLL   = 6'h00;
    localparam logic [5:0] EXE_SRL   = 6'h02;
    localparam logic [5:0] EXE_SRA   = 6'h03;
    localparam logic [5:0] EXE_SLLV  = 6'h04;
    localparam logic [5:0] EXE_SRLV  = 6'h06;
    localparam logic [5:0] EXE_SRAV  = 6'h07;
    localparam logic [5:0] EXE_MOVZ  = 6'h0A;
    localparam logic [5:0] EXE_MOVN  = 6'h0B;
    localparam logic [5:0] EXE_MFHI  = 6'h10;
    localparam logic [5:0] EXE_MTHI  = 6'h11;
    localparam logic [5:0] EXE_MFLO  = 6'h12;
    localparam logic [5:0] EXE_MTLO  = 6'h13;
    localparam logic [5:0] EXE_MULT  = 6'h18;
    localparam logic [5:0] EXE_MULTU = 6'h19;
    localparam logic [5:0] EXE_ADD   = 6'h20;
    localparam logic [5:0] EXE_ADDU  = 6'h21;
    localparam logic [5:0] EXE_SUB   = 6'h22;
    localparam logic [5:0] EXE_SUBU  = 6'h23;
    localparam logic [5:0] EXE_AND   = 6'h24;
    localparam logic [5:0] EXE_OR    = 6'h25;
    localparam logic [5:0] EXE_XOR   = 6'h26;
    localparam logic [5:0] EXE_NOR   = 6'h27;
    localparam logic [5:0] EXE_SLT   = 6'h2A;
    localparam logic [5:0] EXE_SLTU  = 6'h2B;
    localparam logic [5:0] EXE_MUL   = 6'h02;
    localparam logic [5:0] EXE_CLZ   = 6'h20;
    localparam logic [5:0] EXE_CLO   = 6'h21;

    // Operand layout of each op; selects which request fields land in which slots.
    typedef enum logic [3:0] {
        K_RRR, K_SHIFT, K_RD, K_RS, K_RSRT, K_MUL, K_CL, K_IMM, K_LUI, K_NOP, K_BAD
    } enc_kind_e;

    typedef enum logic {ST_IDLE, ST_EMIT2} enc_state_e;

    function automatic logic [31:0] r_word(input logic [5:0] op, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [4:0] rd,
                                           input logic [4:0] sa, input logic [5:0] func);
        return {op, rs, rt, rd, sa, func};
    endfunction

    function automatic logic [31:0] i_word(input logic [5:0] op, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

endpackage

// File: rtl/inst_encoder_word.sv
// Combinational encoder for a single MIPS32 word; LI is resolved by the caller
// into ORI/LUI before it reaches here, so LI and out-of-range ops report !legal.
module inst_enc_word
    import inst_encoder_pkg::*;
(
    input  logic [5:0]  op,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [15:0] imm16,
    input  logic [4:0]  sa,
    output logic [31:0] word,
    output logic        legal
);

    enc_kind_e  kind;
    logic [5:0] code;

    always_comb begin
        kind = K_BAD;
        code = 6'd0;
        case (op)
            ENC_OR:    begin kind = K_RRR;   code = EXE_OR;    end
            ENC_AND:   begin kind = K_RRR;   code = EXE_AND;   end
            ENC_XOR:   begin kind = K_RRR;   code = EXE_XOR;   end
            ENC_NOR:   begin kind = K_RRR;   code = EXE_NOR;   end
            ENC_SLL:   begin kind = K_SHIFT; code = EXE_SLL;   end
            ENC_SRL:   begin kind = K_SHIFT; code = EXE_SRL;   end
            ENC_SRA:   begin kind = K_SHIFT; code = EXE_SRA;   end
            ENC_SLLV:  begin kind = K_RRR;   code = EXE_SLLV;  end
            ENC_SRLV:  begin kind = K_RRR;   code = EXE_SRLV;  end
            ENC_SRAV:  begin kind = K_RRR;   code = EXE_SRAV;  end
            ENC_MOVZ:  begin kind = K_RRR;   code = EXE_MOVZ;  end
            ENC_MOVN:  begin kind = K_RRR;   code = EXE_MOVN;  end
            ENC_MFHI:  begin kind = K_RD;    code = EXE_MFHI;  end
            ENC_MTHI:  begin kind = K_RS;    code = EXE_MTHI;  end
            ENC_MFLO:  begin kind = K_RD;    code = EXE_MFLO;  end
            ENC_MTLO:  begin kind = K_RS;    code = EXE_MTLO;  end
            ENC_SLT:   begin kind = K_RRR;   code = EXE_SLT;   end
            ENC_SLTU:  begin kind = K_RRR;   code = EXE_SLTU;  end
            ENC_ADD:   begin kind = K_RRR;   code = EXE_ADD;   end
            ENC_ADDU:  begin kind = K_RRR;   code = EXE_ADDU;  end
            ENC_SUB:   begin kind = K_RRR;   code = EXE_SUB;   end
            ENC_SUBU:  begin kind = K_RRR;   code = EXE_SUBU;  end
            ENC_MULT:  begin kind = K_RSRT;  code = EXE_MULT;  end
            ENC_MULTU: begin kind = K_RSRT;  code = EXE_MULTU; end
            ENC_ORI:   begin kind = K_IMM;   code = EXE_ORI;   end
            ENC_ANDI:  begin kind = K_IMM;   code = EXE_ANDI;  end
            ENC_XORI:  begin kind = K_IMM;   code = EXE_XORI;  end
            ENC_LUI:   begin kind = K_LUI;   code = EXE_LUI;   end
            ENC_ADDI:  begin kind = K_IMM;   code = EXE_ADDI;  end
            ENC_ADDIU: begin kind = K_IMM;   code = EXE_ADDIU; end
            ENC_SLTI:  begin kind = K_IMM;   code = EXE_SLTI;  end
            ENC_SLTIU: begin kind = K_IMM;   code = EXE_SLTIU; end
            ENC_CLZ:   begin kind = K_CL;    code = EXE_CLZ;   end
            ENC_CLO:   begin kind = K_CL;    code = EXE_CLO;   end
            ENC_MUL:   begin kind = K_MUL;   code = EXE_MUL;   end
            ENC_NOP:   begin kind = K_NOP;   code = 6'd0;      end
            default:   begin kind = K_BAD;   code = 6'd0;      end
        endcase
    end

    always_comb begin
        word  = 32'd0;
        legal = 1'b1;
        case (kind)
            K_RRR:   word = r_word(EXE_SPECIAL, rs, rt, rd, 5'd0, code);
            K_SHIFT: word = r_word(EXE_SPECIAL, 5'd0, rt, rd, sa, code);
            K_RD:    word = r_word(EXE_SPECIAL, 5'd0, 5'd0, rd, 5'd0, code);
            K_RS:    word = r_word(EXE_SPECIAL, rs, 5'd0, 5'd0, 5'd0, code);
            K_RSRT:  word = r_word(EXE_SPECIAL, rs, rt, 5'd0, 5'd0, code);
            K_MUL:   word = r_word(EXE_SPECIAL2, rs, rt, rd, 5'd0, code);
            K_CL:    word = r_word(EXE_SPECIAL2, rs, rd, rd, 5'd0, code);
            K_IMM:   word = i_word(code, rs, rd, imm16);
            K_LUI:   word = i_word(code, 5'd0, rd, imm16);
            K_NOP:   word = 32'd0;
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/inst_encoder.sv
// Valid/ready micro-op to MIPS32 word encoder with one registered output stage;
// LI with both halves non-zero is split into LUI then ORI across two hand-offs.
module inst_encoder
    import inst_encoder_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [5:0]       req_op,
    input  logic [4:0]       req_rd,
    input  logic [4:0]       req_rs,
    input  logic [4:0]       req_rt,
    input  logic [31:0]      req_imm,
    output logic             inst_valid,
    input  logic             inst_ready,
    output logic [31:0]      inst_o,
    output logic             inst_last,
    output logic             err_o,
    output logic [CNT_W-1:0] inst_count_o
);

    enc_state_e       state_q, state_d;
    logic             vld_q, vld_d;
    logic [31:0]      inst_q, inst_d;
    logic             last_q, last_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [4:0]       li_rd_q, li_rd_d;
    logic [15:0]      li_lo_q, li_lo_d;

    logic        is_li, li_hi_zero, li_lo_zero, li_split;
    logic        handoff, accept;
    logic [5:0]  enc_op;
    logic [4:0]  enc_rd, enc_rs, enc_rt, enc_sa;
    logic [15:0] enc_imm;
    logic [31:0] enc_word;
    logic        enc_legal;

    assign is_li      = (req_op == ENC_LI);
    assign li_hi_zero = (req_imm[31:16] == 16'd0);
    assign li_lo_zero = (req_imm[15:0] == 16'd0);
    assign li_split   = is_li && !li_hi_zero && !li_lo_zero;
    assign handoff    = vld_q && inst_ready;

    // EMIT2 never accepts, so one encoder serves both the request and the pending ORI.
    always_comb begin
        enc_op  = req_op;
        enc_rd  = req_rd;
        enc_rs  = req_rs;
        enc_rt  = req_rt;
        enc_imm = req_imm[15:0];
        enc_sa  = req_imm[4:0];
        if (state_q == ST_EMIT2) begin
            enc_op  = ENC_ORI;
            enc_rd  = li_rd_q;
            enc_rs  = li_rd_q;
            enc_rt  = 5'd0;
            enc_imm = li_lo_q;
            enc_sa  = 5'd0;
        end else if (is_li) begin
            enc_op  = li_hi_zero ? ENC_ORI : ENC_LUI;
            enc_rs  = 5'd0;
            enc_rt  = 5'd0;
            enc_imm = li_hi_zero ? req_imm[15:0] : req_imm[31:16];
            enc_sa  = 5'd0;
        end
    end

    inst_enc_word u_word (
        .op    (enc_op),
        .rd    (enc_rd),
        .rs    (enc_rs),
        .rt    (enc_rt),
        .imm16 (enc_imm),
        .sa    (enc_sa),
        .word  (enc_word),
        .legal (enc_legal)
    );

    always_comb begin
        state_d   = state_q;
        vld_d     = vld_q;
        inst_d    = inst_q;
        last_d    = last_q;
        err_d     = 1'b0;
        cnt_d     = cnt_q;
        li_rd_d   = li_rd_q;
        li_lo_d   = li_lo_q;
        req_ready = 1'b0;
        accept    = 1'b0;

        if (handoff) begin
            cnt_d = cnt_q + CNT_W'(1);
            vld_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                req_ready = !rst && (!vld_q || inst_ready);
                accept    = req_valid && req_ready;
                if (accept) begin
                    if (!enc_legal) begin
                        err_d = 1'b1;
                    end else begin
                        vld_d   = 1'b1;
                        inst_d  = enc_word;
                        last_d  = !li_split;
                        li_rd_d = req_rd;
                        li_lo_d = req_imm[15:0];
                        if (li_split) state_d = ST_EMIT2;
                    end
                end
            end
            ST_EMIT2: begin
                if (handoff) begin
                    vld_d   = 1'b1;
                    inst_d  = enc_word;
                    last_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            vld_q   <= 1'b0;
            inst_q  <= 32'd0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            li_rd_q <= 5'd0;
            li_lo_q <= 16'd0;
        end else begin
            state_q <= state_d;
            vld_q   <= vld_d;
            inst_q  <= inst_d;
            last_q  <= last_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            li_rd_q <= li_rd_d;
            li_lo_q <= li_lo_d;
        end
    end

    assign inst_valid   = vld_q;
    assign inst_o       = inst_q;
    assign inst_last    = last_q;
    assign err_o        = err_q;
    assign inst_count_o = cnt_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Directed bench for inst_encoder: hand-computed MIPS32 words, LI split/stall,
// illegal op, counter wrap (narrow counter) and reset in the middle of an LI.
module tb_inst_encoder;
    import inst_encoder_pkg::*;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [5:0]    req_op;
    logic [4:0]    req_rd, req_rs, req_rt;
    logic [31:0]   req_imm;
    logic          inst_valid;
    logic          inst_ready;
    logic [31:0]   inst_o;
    logic          inst_last;
    logic          err_o;
    logic [CW-1:0] inst_count_o;

    int passed = 0;
    int total  = 0;
    int exp_cnt = 0;

    inst_encoder #(.CNT_W(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_rd       (req_rd),
        .req_rs       (req_rs),
        .req_rt       (req_rt),
        .req_imm      (req_imm),
        .inst_valid   (inst_valid),
        .inst_ready   (inst_ready),
        .inst_o       (inst_o),
        .inst_last    (inst_last),
        .err_o        (err_o),
        .inst_count_o (inst_count_o)
    );

    always #5 clk = ~clk;

    // Presents a request and returns 1ns after the accepting edge.
    task automatic send(input logic [5:0] op, input logic [4:0] rd, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [31:0] imm);
        int n = 0;
        req_op = op; req_rd = rd; req_rs = rs; req_rt = rt; req_imm = imm;
        req_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (req_ready) break;
            n++;
            if (n > 20) begin
                total++;
                $display("FAIL send_timeout: req_ready stayed 0 for op %0d, want 1", op);
                break;
            end
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b1; req_op = ENC_OR; inst_ready = 1'b1;
        req_rd = 5'd1; req_rs = 5'd1; req_rt = 5'd1; req_imm = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (req_ready !== 1'b0) $display("FAIL rst_req_ready: got %b want 0", req_ready); else passed++;
        total++; if (inst_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", inst_valid); else passed++;
        total++; if (inst_o !== 32'd0) $display("FAIL rst_inst: got %h want 00000000", inst_o); else passed++;
        total++; if (inst_last !== 1'b0 || err_o !== 1'b0)
            $display("FAIL rst_last_err: got %b%b want 00", inst_last, err_o); else passed++;
        total++; if (inst_count_o !== 4'd0) $display("FAIL rst_count: got %0d want 0", inst_count_o); else passed++;
        req_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_or();
        inst_ready = 1'b1;
        send(ENC_OR, 5'd3, 5'd1, 5'd2, 32'd0);
        total++; if (inst_valid !== 1'b1) $display("FAIL or_valid: got %b want 1", inst_valid); else passed++;
        total++; if (inst_o !== 32'h00221825) $display("FAIL or_word: got %h want 00221825", inst_o); else passed++;
        total++; if (inst_last !== 1'b1) $display("FAIL or_last: got %b want 1", inst_last); else passed++;
        @(posedge clk); #1;
        exp_cnt += 1;
        total++; if (inst_valid !== 1'b0) $display("FAIL or_drain: got %b want 0", inst_valid); else passed++;
        total++; if (inst_count_o !== 4'(exp_cnt)) $display("FAIL or_count: got %0d want %0d", inst_count_o, 4'(exp_cnt)); else passed++;
    endtask

    task automatic test_li_split();
        inst_ready = 1'b1;
        send(ENC_LI, 5'd4, 5'd0, 5'd0, 32'h12345678);
        total++; if (inst_o !== 32'h3C041234 || inst_last !== 1'b0)
            $display("FAIL li_lui: got %h last %b want 3c041234 last 0", inst_o, inst_last); else passed++;
        total++; if (req_ready !== 1'b0) $display("FAIL li_busy: got req_ready %b want 0", req_ready); else passed++;
        @(posedge clk); #1;
        total++; if (inst_valid !== 1'b1 || inst_o !== 32'h34845678 || inst_last !== 1'b1)
            $display("FAIL li_ori: got v%b %h last %b want v1 34845678 last 1", inst_valid, inst_o, inst_last); else passed++;
        @(posedge clk); #1;
        exp_cnt += 2;
        total++; if (inst_valid !== 1'b0 || inst_count_o !== 4'(exp_cnt))
            $display("FAIL li_done: got v%b cnt %0d want v0 cnt %0d", inst_valid, inst_count_o, 4'(exp_cnt)); else passed++;
    endtask

    task automatic test_single();
        logic [5:0]  ops [8] = '{ENC_LI, ENC_SLL, ENC_LI, ENC_ADDIU, ENC_MUL, ENC_CLZ, ENC_MFHI, ENC_NOP};
        logic [4:0]  rds [8] = '{5'd4, 5'd2, 5'd5, 5'd5, 5'd3, 5'd7, 5'd8, 5'd0};
        logic [4:0]  rss [8] = '{5'd0, 5'd0, 5'd0, 5'd6, 5'd1, 5'd9, 5'd0, 5'd0};
        logic [4:0]  rts [8] = '{5'd0, 5'd1, 5'd0, 5'd0, 5'd2, 5'd0, 5'd0, 5'd0};
        logic [31:0] ims [8] = '{32'h000000FF, 32'd4, 32'hABCD0000, 32'h0000FFFF, 32'd0, 32'd0, 32'd0, 32'd0};
        logic [31:0] exs [8] = '{32'h340400FF, 32'h00011100, 32'h3C05ABCD, 32'h24C5FFFF,
                                 32'h70221802, 32'h71273820, 32'h00004010, 32'h00000000};
        inst_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send(ops[i], rds[i], rss[i], rts[i], ims[i]);
            total++; if (inst_valid !== 1'b1 || inst_o !== exs[i] || inst_last !== 1'b1)
                $display("FAIL single_%0d: got v%b %h last %b want v1 %h last 1",
                         i, inst_valid, inst_o, inst_last, exs[i]); else passed++;
            @(posedge clk); #1;
            exp_cnt += 1;
        end
        total++; if (inst_valid !== 1'b0 || inst_count_o !== 4'(exp_cnt))
            $display("FAIL single_done: got v%b cnt %0d want v0 cnt %0d", inst_valid, inst_count_o, 4'(exp_cnt)); else passed++;
    endtask

    task automatic test_back_to_back();
        inst_ready = 1'b1;
        send(ENC_OR, 5'd3, 5'd1, 5'd2, 32'd0);
        req_valid = 1'b1; req_op = ENC_AND; req_rd = 5'd7; req_rs = 5'd5; req_rt = 5'd6;
        total++; if (req_ready !== 1'b1) $display("FAIL b2b_ready: got %b want 1", req_ready); else passed++;
        total++; if (inst_o !== 32'h00221825) $display("FAIL b2b_w0: got %h want 00221825", inst_o); else passed++;
        @(posedge clk); #1;
        req_valid = 1'b0;
        total++; if (inst_valid !== 1'b1 || inst_o !== 32'h00A63824)
            $display("FAIL b2b_w1: got v%b %h want v1 00a63824", inst_valid, inst_o); else passed++;
        @(posedge clk); #1;
        exp_cnt += 2;
        total++; if (inst_valid !== 1'b0 || inst_count_o !== 4'(exp_cnt))
            $display("FAIL b2b_done: got v%b cnt %0d want v0 cnt %0d", inst_valid, inst_count_o, 4'(exp_cnt)); else passed++;
    endtask

    task automatic test_stall();
        inst_ready = 1'b0;
        send(ENC_LI, 5'd4, 5'd0, 5'd0, 32'h12345678);
        req_rd = 5'd31; req_imm = 32'hFFFFFFFF;
        for (int i = 0; i < 3; i++) begin
            total++; if (inst_valid !== 1'b1 || inst_o !== 32'h3C041234 || inst_last !== 1'b0 || req_ready !== 1'b0)
                $display("FAIL stall_hold_%0d: got v%b %h last %b rdy %b want v1 3c041234 last 0 rdy 0",
                         i, inst_valid, inst_o, inst_last, req_ready); else passed++;
            @(posedge clk); #1;
        end
        inst_ready = 1'b1;
        @(posedge clk); #1;
        total++; if (inst_o !== 32'h34845678 || inst_last !== 1'b1)
            $display("FAIL stall_ori: got %h last %b want 34845678 last 1", inst_o, inst_last); else passed++;
        @(posedge clk); #1;
        exp_cnt += 2;
        total++; if (inst_count_o !== 4'(exp_cnt)) $display("FAIL stall_count: got %0d want %0d", inst_count_o, 4'(exp_cnt)); else passed++;
    endtask

    task automatic test_illegal();
        inst_ready = 1'b1;
        send(6'h3F, 5'd1, 5'd1, 5'd1, 32'd0);
        total++; if (err_o !== 1'b1 || inst_valid !== 1'b0)
            $display("FAIL illegal_err: got err %b v%b want err 1 v0", err_o, inst_valid); else passed++;
        @(posedge clk); #1;
        total++; if (err_o !== 1'b0 || inst_valid !== 1'b0)
            $display("FAIL illegal_pulse: got err %b v%b want err 0 v0", err_o, inst_valid); else passed++;
        send(ENC_OR, 5'd3, 5'd1, 5'd2, 32'd0);
        total++; if (inst_o !== 32'h00221825 || inst_valid !== 1'b1)
            $display("FAIL illegal_next: got v%b %h want v1 00221825", inst_valid, inst_o); else passed++;
        @(posedge clk); #1;
        exp_cnt += 1;
    endtask

    task automatic test_wrap();
        inst_ready = 1'b1;
        req_op = ENC_NOP; req_valid = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        exp_cnt += 10;
        total++; if (inst_count_o !== 4'(exp_cnt)) $display("FAIL wrap_count: got %0d want %0d", inst_count_o, 4'(exp_cnt)); else passed++;
    endtask

    task automatic test_rst_mid_li();
        inst_ready = 1'b0;
        send(ENC_LI, 5'd4, 5'd0, 5'd0, 32'h12345678);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_cnt = 0;
        total++; if (inst_valid !== 1'b0 || inst_count_o !== 4'd0 || inst_o !== 32'd0)
            $display("FAIL rstmid_state: got v%b cnt %0d %h want v0 cnt 0 00000000", inst_valid, inst_count_o, inst_o); else passed++;
        inst_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            total++; if (inst_valid !== 1'b0) $display("FAIL rstmid_noori_%0d: got v%b %h want v0", i, inst_valid, inst_o); else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_or();
        test_li_split();
        test_single();
        test_back_to_back();
        test_stall();
        test_illegal();
        test_wrap();
        test_rst_mid_li();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
